ram_march_bist: RTL and testbench

//  March C- self-test initiator for a single-port synchronous RAM (clk/we/addr/din/dout, 1-cycle read latency).

---
 rtl/ram_march_bist_pkg.sv | 51 +++++
 rtl/ram_march_bist_if.sv | 38 +++
 rtl/ram_march_bist_addr_gen.sv | 40 ++++
 rtl/ram_march_bist.sv | 169 ++++++++++++++++
 tb/tb_ram_march_bist.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ram_march_bist_pkg.sv
// ============================================================================
//  Module : ram_march_bist_pkg
//  Brief  : March C- element table, FSM state and op type for ram_march_bist
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_march_bist_pkg;

  localparam int N_ELEM = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Per-element op list; polarity 0 = background, 1 = inverted background
  typedef struct packed {
    logic two_ops;
    op_t  op0;
    logic pol0;
    op_t  op1;
    logic pol1;
  } elem_t;

  function automatic elem_t elem_ops(input logic [2:0] idx);
    case (idx)
      3'd0:    elem_ops = '{1'b0, OP_WR, 1'b0, OP_WR, 1'b0};
      3'd1:    elem_ops = '{1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
      3'd2:    elem_ops = '{1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
      3'd3:    elem_ops = '{1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
      3'd4:    elem_ops = '{1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
      3'd5:    elem_ops = '{1'b0, OP_RD, 1'b0, OP_RD, 1'b0};
      default: elem_ops = '{1'b0, OP_RD, 1'b0, OP_RD, 1'b0};
    endcase
  endfunction

  // Address direction of each element: 1 = descending
  function automatic logic elem_down(input logic [2:0] idx);
    elem_down = (idx == 3'd3) || (idx == 3'd4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_march_bist_if.sv
// ============================================================================
//  Module : ram_march_bist_if
//  Brief  : Control, status and RAM-port bundle of the March C- BIST
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_march_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp;
  logic [DATA_W-1:0] fail_got;

  modport master (
    input  start, ram_dout,
    output busy, done, pass, ram_we, ram_addr, ram_din,
           fail_elem, fail_addr, fail_exp, fail_got
  );

  modport slave (
    output start, ram_dout,
    input  busy, done, pass, ram_we, ram_addr, ram_din,
           fail_elem, fail_addr, fail_exp, fail_got
  );
endinterface

`default_nettype wire

// File: rtl/ram_march_bist_addr_gen.sv
// ============================================================================
//  Module : ram_march_bist_addr_gen
//  Brief  : March address counter; loads 0 or DEPTH-1 by direction, no wrap
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_march_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic              i_down,
  input  wire logic              i_step,
  output logic      [ADDR_W-1:0] o_addr,
  output logic                   o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_down;

  assign o_addr = r_addr;
  assign o_last = r_down ? (r_addr == '0) : (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_down <= i_down;
      r_addr <= i_down ? {ADDR_W{1'b1}} : '0;
    end else if (i_step && !o_last) begin
      r_addr <= r_down ? r_addr - 1'b1 : r_addr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_march_bist.sv
// ============================================================================
//  Module : ram_march_bist
//  Brief  : March C- self-test initiator for a 1-cycle-latency single-port RAM
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_march_bist
  import ram_march_bist_pkg::*;
#(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input wire logic          clk,
  input wire logic          rst,
  ram_march_bist_if.master  bus
);

  state_t            r_state;
  logic              r_busy, r_done, r_pass;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [2:0]        r_fail_elem;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_exp, r_fail_got;
  logic [2:0]        r_elem, r_out_elem;
  logic              r_opi;
  logic              r_rd_issue;
  logic              r_chk_vld;
  logic [2:0]        r_chk_elem;
  logic [ADDR_W-1:0] r_chk_addr;
  logic [DATA_W-1:0] r_chk_exp;

  elem_t             w_cur;
  op_t               w_op;
  logic              w_pol, w_last_op;
  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch, w_accept, w_emit, w_elem_end;
  logic              w_ag_load, w_ag_down, w_ag_step, w_ag_last;
  logic [ADDR_W-1:0] w_ag_addr;

  always_comb begin
    w_cur      = elem_ops(r_elem);
    w_op       = r_opi ? w_cur.op1  : w_cur.op0;
    w_pol      = r_opi ? w_cur.pol1 : w_cur.pol0;
    w_last_op  = r_opi || !w_cur.two_ops;
    w_exp      = w_pol ? ~BG : BG;
    w_mismatch = r_chk_vld && (bus.ram_dout != r_chk_exp);
    w_accept   = (r_state == S_IDLE) && bus.start;
    w_emit     = (r_state == S_RUN) && !w_mismatch;
    w_elem_end = w_emit && w_last_op && w_ag_last;
    w_ag_load  = w_accept || (w_elem_end && (r_elem != 3'(N_ELEM - 1)));
    w_ag_down  = w_accept ? elem_down(3'd0) : elem_down(r_elem + 3'd1);
    w_ag_step  = w_emit && w_last_op && !w_ag_last;
  end

  ram_march_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ag_load),
    .i_down (w_ag_down),
    .i_step (w_ag_step),
    .o_addr (w_ag_addr),
    .o_last (w_ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_fail_elem <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_elem      <= '0;
      r_out_elem  <= '0;
      r_opi       <= 1'b0;
      r_rd_issue  <= 1'b0;
      r_chk_vld   <= 1'b0;
      r_chk_elem  <= '0;
      r_chk_addr  <= '0;
      r_chk_exp   <= '0;
    end else begin
      // A read presented last cycle has its data on ram_dout next cycle
      r_chk_vld  <= r_rd_issue;
      r_chk_elem <= r_out_elem;
      r_chk_addr <= r_addr;
      r_chk_exp  <= r_din;
      r_rd_issue <= 1'b0;
      r_we       <= 1'b0;

      if ((r_state != S_IDLE) && w_mismatch) begin
        r_fail_elem <= r_chk_elem;
        r_fail_addr <= r_chk_addr;
        r_fail_exp  <= r_chk_exp;
        r_fail_got  <= bus.ram_dout;
        r_done      <= 1'b1;
        r_pass      <= 1'b0;
        r_busy      <= 1'b0;
        r_chk_vld   <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_state     <= S_RUN;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_pass      <= 1'b0;
              r_fail_elem <= '0;
              r_fail_addr <= '0;
              r_fail_exp  <= '0;
              r_fail_got  <= '0;
              r_elem      <= '0;
              r_opi       <= 1'b0;
            end
          end
          S_RUN: begin
            r_we       <= (w_op == OP_WR);
            r_addr     <= w_ag_addr;
            r_din      <= w_exp;
            r_out_elem <= r_elem;
            r_rd_issue <= (w_op == OP_RD);
            r_opi      <= !w_last_op;
            if (w_elem_end) begin
              if (r_elem == 3'(N_ELEM - 1)) begin
                r_state <= S_DRAIN;
              end else begin
                r_elem <= r_elem + 3'd1;
              end
            end
          end
          S_DRAIN: begin
            if (r_chk_vld && !r_rd_issue) begin
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_din   = r_din;
  assign bus.fail_elem = r_fail_elem;
  assign bus.fail_addr = r_fail_addr;
  assign bus.fail_exp  = r_fail_exp;
  assign bus.fail_got  = r_fail_got;

endmodule

`default_nettype wire

// File: tb/tb_ram_march_bist.sv
// ============================================================================
//  Module : tb_ram_march_bist
//  Brief  : Directed bench for ram_march_bist with a 16x8 RAM and fault modes
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_march_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_march_bist #(.ADDR_W(4), .DATA_W(8), .BG(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: 0 = fault-free, 1 = dout[0] stuck at 1 on addr 4, 2 = write to 9 also hits 8
  int         fault_mode = 0;
  logic [7:0] mem [16];
  logic [7:0] r_q = 8'h00;
  logic [3:0] r_qaddr = 4'd0;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
      if (fault_mode == 2 && bus.ram_addr == 4'd9) mem[8] <= bus.ram_din;
    end
    r_q     <= mem[bus.ram_addr];
    r_qaddr <= bus.ram_addr;
  end
  assign bus.ram_dout = r_q | ((fault_mode == 1 && r_qaddr == 4'd4) ? 8'h01 : 8'h00);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected March C- op stream, built from the element table
  int   e_nops [6] = '{1, 2, 2, 2, 2, 1};
  bit   e_down [6] = '{0, 0, 0, 1, 1, 0};
  bit   e_w0   [6] = '{1, 0, 0, 0, 0, 0};
  bit   e_v0   [6] = '{0, 0, 1, 0, 1, 0};
  bit   e_w1   [6] = '{0, 1, 1, 1, 1, 0};
  bit   e_v1   [6] = '{0, 1, 0, 1, 0, 0};
  logic       x_we   [160];
  logic [3:0] x_addr [160];
  logic [7:0] x_din  [160];

  typedef struct {
    int         fault;
    int         restart_at;
    int         done_edge;
    logic       pass;
    logic [2:0] elem;
    logic [3:0] addr;
    logic [7:0] exp;
    logic [7:0] got;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [38:0] all_outs();
    return {bus.ram_we, bus.ram_addr, bus.ram_din, bus.busy, bus.done, bus.pass,
            bus.fail_elem, bus.fail_addr, bus.fail_exp, bus.fail_got};
  endfunction

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic run(input int restart_at, output int done_edge, output int busy_cnt,
                     output int op_errs);
    pulse_start();
    chk("start_clear", {60'd0, bus.busy, bus.done, bus.pass, 1'b0} |
        {25'd0, bus.fail_elem, bus.fail_addr, bus.fail_exp, bus.fail_got}, 64'h8);
    done_edge = -1;
    busy_cnt  = 0;
    op_errs   = 0;
    for (int e = 1; e <= 400; e++) begin
      if (e == restart_at) bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        done_edge = e;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (e <= 160 && (bus.ram_we !== x_we[e-1] || bus.ram_addr !== x_addr[e-1] ||
                       bus.ram_din !== x_din[e-1]))
        op_errs++;
    end
  endtask

  initial begin
    int k;
    int d, b, o;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5;

    k = 0;
    for (int el = 0; el < 6; el++)
      for (int j = 0; j < 16; j++)
        for (int p = 0; p < e_nops[el]; p++) begin
          x_we[k]   = (p == 0) ? e_w0[el] : e_w1[el];
          x_addr[k] = e_down[el] ? 4'(15 - j) : 4'(j);
          x_din[k]  = ((p == 0) ? e_v0[el] : e_v1[el]) ? 8'hFF : 8'h00;
          k++;
        end

    vecs[0] = '{0,  0, 162, 1'b1, 3'd0, 4'd0, 8'h00, 8'h00};
    vecs[1] = '{1,  0,  27, 1'b0, 3'd1, 4'd4, 8'h00, 8'h01};
    vecs[2] = '{0,  0, 162, 1'b1, 3'd0, 4'd0, 8'h00, 8'h00};
    vecs[3] = '{2,  0,  97, 1'b0, 3'd3, 4'd8, 8'h00, 8'hFF};
    vecs[4] = '{0, 40, 162, 1'b1, 3'd0, 4'd0, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 64'(all_outs()), 64'd0);

    for (int v = 0; v < 5; v++) begin
      fault_mode = vecs[v].fault;
      run(vecs[v].restart_at, d, b, o);
      chk($sformatf("v%0d_done_edge", v), 64'(d), 64'(vecs[v].done_edge));
      chk($sformatf("v%0d_busy_cycles", v), 64'(b), 64'(vecs[v].done_edge - 1));
      chk($sformatf("v%0d_op_seq_errs", v), 64'(o), 64'd0);
      chk($sformatf("v%0d_pass", v), 64'(bus.pass), 64'(vecs[v].pass));
      chk($sformatf("v%0d_busy_at_done", v), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_fail_rec", v),
          64'({bus.fail_elem, bus.fail_addr, bus.fail_exp, bus.fail_got}),
          64'({vecs[v].elem, vecs[v].addr, vecs[v].exp, vecs[v].got}));
      @(negedge clk);
      chk($sformatf("v%0d_we_idle", v), 64'(bus.ram_we), 64'd0);
      chk($sformatf("v%0d_done_held", v), 64'({bus.done, bus.pass}), 64'({1'b1, vecs[v].pass}));
    end

    // Reset in the middle of a run
    fault_mode = 0;
    pulse_start();
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_result", 64'({bus.busy, bus.done, bus.pass, bus.ram_we}), 64'd0);
    run(0, d, b, o);
    chk("after_rst_done_edge", 64'(d), 64'd162);
    chk("after_rst_pass", 64'(bus.pass), 64'd1);
    chk("after_rst_ops", 64'(o), 64'd0);

    // start and rst together: rst wins
    @(negedge clk);
    bus.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_rst_same", 64'(all_outs()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
